// File: rtl/sw_sig_conditioner.sv
// sw_sig_conditioner: conditions raw asynchronous status signals for a
// software-polled input PIO. Each channel gets a two-flop synchroniser, a
// counter-based debounce FSM with glitch rejection, and registered one-cycle
// rise/fall strobes.
//
// Optional build macro SW_SIG_PULSE_STRETCH_EN: holds sig_out high for at
// least STRETCH_CYCLES after every accepted rise, so that software polling
// cannot miss short events. When the macro is undefined, sig_out is the
// debounced level.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   sig_raw     [WIDTH] raw asynchronous inputs
//   sig_out     [WIDTH] conditioned level (drives PIO in_port)
//   rise_pulse  [WIDTH] one-cycle strobe on accepted rise
//   fall_pulse  [WIDTH] one-cycle strobe on accepted fall
//   busy        any channel currently qualifying a new level

module sw_sig_chan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic sig_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range 2..65535");
  end
  if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > 65535) begin : g_bad_str
    $error("STRETCH_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s1, s2;
  logic          deb, deb_nxt;
  logic          out_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any disagreeing sample during a WAIT state aborts back to the stable
  // state, so a bounce restarts qualification from cnt=0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = deb;
    case (state)
      STABLE_LO: if (s2) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = '0;
      end
      WAIT_HI: begin
        if (!s2)                               state_nxt = STABLE_LO;
        else if (cnt == CW'(DEBOUNCE_CYCLES-1)) begin
          state_nxt = STABLE_HI;
          deb_nxt   = 1'b1;
        end else                               cnt_nxt = cnt + CW'(1);
      end
      STABLE_HI: if (!s2) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = '0;
      end
      WAIT_LO: begin
        if (s2)                                state_nxt = STABLE_HI;
        else if (cnt == CW'(DEBOUNCE_CYCLES-1)) begin
          state_nxt = STABLE_LO;
          deb_nxt   = 1'b0;
        end else                               cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = STABLE_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      deb   <= deb_nxt;
    end
  end

`ifdef SW_SIG_PULSE_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] stretch, stretch_nxt;

  // Reload on every accepted rise, including one that lands mid-stretch.
  always_comb begin
    stretch_nxt = stretch;
    if (deb_nxt && !deb)      stretch_nxt = SW'(STRETCH_CYCLES);
    else if (stretch != '0)   stretch_nxt = stretch - SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stretch <= '0;
    else          stretch <= stretch_nxt;
  end

  assign out_nxt = deb_nxt | (stretch_nxt != '0);
`else
  assign out_nxt = deb_nxt;
`endif

  // Strobes are registered alongside deb, so they coincide with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sig_out    <= out_nxt;
      rise_pulse <= deb_nxt & ~deb;
      fall_pulse <= deb & ~deb_nxt;
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);
endmodule

module sw_sig_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sig_raw,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             busy
);
  logic [WIDTH-1:0] chan_busy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_sig_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (sig_raw[i]),
      .sig_out   (sig_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .busy      (chan_busy[i])
    );
  end

  assign busy = |chan_busy;
endmodule

// File: tb/tb_sw_sig_conditioner.sv
// Directed bench for sw_sig_conditioner with DEBOUNCE_CYCLES=4,
// STRETCH_CYCLES=10, WIDTH=2. Edge k counts from the first clock edge that
// samples a new raw level; outputs are sampled 1 time unit after each edge.
// Observed vector layout: {sig_out[1:0], rise_pulse[1:0], fall_pulse[1:0], busy}.

module tb_sw_sig_conditioner;
  logic       clk;
  logic       reset_n;
  logic [1:0] sig_raw;
  logic [1:0] sig_out, rise_pulse, fall_pulse;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [6:0] obs, exp_v;

  sw_sig_conditioner #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (10)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sig_raw   (sig_raw),
    .sig_out   (sig_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sig_raw = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    obs = {sig_out, rise_pulse, fall_pulse, busy};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 7'b0);
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  // ch0 rise held: accepted on edge 7, busy on edges 3..6, ch1 untouched.
  task automatic test_rise;
    sig_raw = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp_v = {(k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00, 2'b00,
               1'(k >= 3 && k <= 6)};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL rise edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
    idle(12);
  endtask

  // ch1 high for 3 samples only: qualification aborts at cnt=2.
  task automatic test_glitch;
    sig_raw[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      exp_v = {2'b01, 2'b00, 2'b00, 1'(k >= 3 && k <= 5)};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL glitch edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
      if (k == 3) sig_raw[1] = 1'b0;
    end
  endtask

  // ch0 falls, bounces high for 2 cycles, then stays low.
  task automatic test_bounce_fall;
    sig_raw[0] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      exp_v = {1'b0, 1'(k < 12), 2'b00, 1'b0, 1'(k == 12),
               1'((k >= 3 && k <= 5) || (k >= 8 && k <= 11))};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL bounce_fall edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
      if (k == 3) sig_raw[0] = 1'b1;
      if (k == 5) sig_raw[0] = 1'b0;
    end
    idle(4);
  endtask

  task automatic test_both;
    logic [31:0] readdata;
    sig_raw = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp_v = {(k >= 7) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00, 2'b00,
               1'(k >= 3 && k <= 6)};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL both edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
    readdata = {30'b0, sig_out};
    checks++;
    if (readdata !== 32'h3) begin
      failures++;
      $display("FAIL pio_readdata obs=%h exp=%h", readdata, 32'h3);
    end
    sig_raw = 2'b00;
    idle(20);
  endtask

  task automatic test_reset_mid;
    sig_raw = 2'b10;
    idle(10);
    sig_raw = 2'b11;
    repeat (4) @(posedge clk); #1;
    obs = {sig_out, rise_pulse, fall_pulse, busy};
    checks++;
    if (obs !== 7'b10_00_00_1) begin
      failures++;
      $display("FAIL pre_reset obs=%b exp=%b", obs, 7'b10_00_00_1);
    end
    #2 reset_n = 1'b0;
    #1;
    obs = {sig_out, rise_pulse, fall_pulse, busy};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 7'b0);
    end
    @(posedge clk); #1;
    obs = {sig_out, rise_pulse, fall_pulse, busy};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_held obs=%b exp=%b", obs, 7'b0);
    end
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp_v = {(k >= 7) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00, 2'b00,
               1'(k >= 3 && k <= 6)};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL post_reset edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
    sig_raw = 2'b00;
    idle(20);
  endtask

  // Short high on ch0: deb rises on edge 7 and falls on edge 12. With
  // stretch, sig_out stays high for 10 cycles (edges 7..16).
  task automatic test_stretch;
    logic so;
    sig_raw = 2'b01;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
`ifdef SW_SIG_PULSE_STRETCH_EN
      so = (k >= 7 && k <= 16);
`else
      so = (k >= 7 && k <= 11);
`endif
      exp_v = {1'b0, so, 1'b0, 1'(k == 7), 1'b0, 1'(k == 12),
               1'((k >= 3 && k <= 6) || (k >= 8 && k <= 11))};
      obs = {sig_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stretch edge=%0d obs=%b exp=%b", k, obs, exp_v);
      end
      if (k == 5) sig_raw[0] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sig_raw = 2'b00;
    test_reset();
    test_rise();
    test_glitch();
    test_bounce_fall();
    test_both();
    test_reset_mid();
    test_stretch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
